// File: rtl/dcache_line_nway.sv
// WAYS-way fully associative data cache with automatic writeback of dirty
// victims and line fill from memory. Victim selection is invalid-first, then
// round-robin.
module dcache_line_nway #(
  parameter int unsigned DATABITS      = 32,
  parameter int unsigned ADDRBITS      = 32,
  parameter int unsigned CACHEADDRBITS = 5,
  parameter int unsigned LSBITS        = 2,
  parameter int unsigned WAYS          = 4,
  parameter int unsigned WAYBITS       = (WAYS > 1) ? $clog2(WAYS) : 1,
  parameter int unsigned CNTMISSBITS   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRBITS-1:0]      dcache_addr,
  input  logic [DATABITS-1:0]      dcache_in,
  input  logic [DATABITS/8-1:0]    byteenable,
  input  logic                     dcache_rdreq,
  input  logic                     dcache_wrreq,
  output logic [DATABITS-1:0]      dcache_out,
  output logic                     dcache_valid,
  output logic                     dcache_busy,
  input  logic                     invalidate,
  output logic [ADDRBITS-1:0]      mem_addr,
  output logic [DATABITS-1:0]      mem_out,
  output logic                     mem_wrreq,
  input  logic                     mem_wr_ack,
  output logic                     mem_rdreq,
  input  logic [DATABITS-1:0]      mem_in,
  input  logic                     mem_in_valid,
  output logic [CNTMISSBITS-1:0]   cnt_miss
);

  localparam int unsigned TAGBITS = ADDRBITS - CACHEADDRBITS - LSBITS;
  localparam int unsigned BANKNUM = DATABITS / 8;
  localparam int unsigned WORDS   = 1 << CACHEADDRBITS;
  localparam logic [CACHEADDRBITS-1:0] LastWord = CACHEADDRBITS'(WORDS - 1);
  localparam logic [WAYBITS-1:0]       LastWay  = WAYBITS'(WAYS - 1);

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e                   state_q, state_d;
  logic [WAYS-1:0]          valid_q, valid_d;
  logic [WAYS-1:0]          dirty_q, dirty_d;
  logic [WAYBITS-1:0]       ptr_q, ptr_d;
  logic [WAYBITS-1:0]       victim_q, victim_d;
  logic [CACHEADDRBITS-1:0] cnt_q, cnt_d;
  logic [TAGBITS-1:0]       req_tag_q, req_tag_d;
  logic [CACHEADDRBITS-1:0] req_word_q, req_word_d;
  logic [DATABITS-1:0]      wdata_q, wdata_d;
  logic [BANKNUM-1:0]       be_q, be_d;
  logic                     is_wr_q, is_wr_d;
  logic [CNTMISSBITS-1:0]   cnt_miss_q, cnt_miss_d;
  logic [DATABITS-1:0]      out_q, out_d;
  logic                     out_valid_q, out_valid_d;

  // Tag and data storage; contents are don't-care after reset.
  logic [TAGBITS-1:0]       tag_q  [WAYS];
  logic [DATABITS-1:0]      data_q [WAYS][WORDS];

  logic                     data_we;
  logic [WAYBITS-1:0]       data_way;
  logic [CACHEADDRBITS-1:0] data_idx;
  logic [DATABITS-1:0]      data_wdata;
  logic                     tag_we;

  logic [TAGBITS-1:0]       in_tag;
  logic [CACHEADDRBITS-1:0] in_word;
  logic                     hit;
  logic [WAYBITS-1:0]       hit_way;
  logic                     inv_found;
  logic [WAYBITS-1:0]       inv_way;
  logic                     unused_lsb;

  assign in_tag     = dcache_addr[ADDRBITS-1 -: TAGBITS];
  assign in_word    = dcache_addr[LSBITS +: CACHEADDRBITS];
  assign unused_lsb = ^dcache_addr[LSBITS-1:0];

  function automatic logic [DATABITS-1:0] merge_bytes(input logic [DATABITS-1:0] old_w,
                                                      input logic [DATABITS-1:0] new_w,
                                                      input logic [BANKNUM-1:0]  be);
    logic [DATABITS-1:0] r;
    r = old_w;
    for (int b = 0; b < BANKNUM; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Hit and first-invalid search; descending scan so the lowest index wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && (tag_q[w] == in_tag)) begin
        hit     = 1'b1;
        hit_way = WAYBITS'(w);
      end
      if (!valid_q[w]) begin
        inv_found = 1'b1;
        inv_way   = WAYBITS'(w);
      end
    end
  end

  // Next-state, storage write port and memory-side outputs.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    req_tag_d   = req_tag_q;
    req_word_d  = req_word_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    is_wr_d     = is_wr_q;
    cnt_miss_d  = cnt_miss_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    data_we     = 1'b0;
    data_way    = victim_q;
    data_idx    = cnt_q;
    data_wdata  = mem_in;
    tag_we      = 1'b0;
    mem_addr    = '0;
    mem_out     = '0;
    mem_wrreq   = 1'b0;
    mem_rdreq   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (invalidate) begin
          valid_d = '0;
          dirty_d = '0;
        end else if (dcache_wrreq || dcache_rdreq) begin
          if (hit) begin
            if (dcache_wrreq) begin
              data_we           = 1'b1;
              data_way          = hit_way;
              data_idx          = in_word;
              data_wdata        = merge_bytes(data_q[hit_way][in_word], dcache_in, byteenable);
              dirty_d[hit_way]  = 1'b1;
            end else begin
              out_d = data_q[hit_way][in_word];
            end
            out_valid_d = 1'b1;
          end else begin
            req_tag_d  = in_tag;
            req_word_d = in_word;
            wdata_d    = dcache_in;
            be_d       = byteenable;
            is_wr_d    = dcache_wrreq;
            if (cnt_miss_q != '1) cnt_miss_d = cnt_miss_q + 1'b1;
            victim_d = inv_found ? inv_way : ptr_q;
            cnt_d    = '0;
            state_d  = (valid_q[victim_d] && dirty_q[victim_d]) ? StWb : StFill;
          end
        end
      end

      StWb: begin
        mem_addr  = {tag_q[victim_q], cnt_q, {LSBITS{1'b0}}};
        mem_out   = data_q[victim_q][cnt_q];
        mem_wrreq = 1'b1;
        if (mem_wr_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            cnt_d   = '0;
            state_d = StFill;
          end
        end
      end

      StFill: begin
        mem_addr  = {req_tag_q, cnt_q, {LSBITS{1'b0}}};
        mem_rdreq = 1'b1;
        if (mem_in_valid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            tag_we            = 1'b1;
            valid_d[victim_q] = 1'b1;
            dirty_d[victim_q] = 1'b0;
            if (victim_q == ptr_q) ptr_d = (ptr_q == LastWay) ? '0 : ptr_q + 1'b1;
            cnt_d   = '0;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        // Replay the latched request against the freshly filled way.
        if (is_wr_q) begin
          data_we           = 1'b1;
          data_idx          = req_word_q;
          data_wdata        = merge_bytes(data_q[victim_q][req_word_q], wdata_q, be_q);
          dirty_d[victim_q] = 1'b1;
        end else begin
          out_d = data_q[victim_q][req_word_q];
        end
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      ptr_q       <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      req_tag_q   <= '0;
      req_word_q  <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      is_wr_q     <= 1'b0;
      cnt_miss_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      req_tag_q   <= req_tag_d;
      req_word_q  <= req_word_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      is_wr_q     <= is_wr_d;
      cnt_miss_q  <= cnt_miss_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Tag and data arrays, written through a single port.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_way][data_idx] <= data_wdata;
    if (tag_we)  tag_q[victim_q] <= req_tag_q;
  end

  assign dcache_out   = out_q;
  assign dcache_valid = out_valid_q;
  assign dcache_busy  = (state_q != StIdle);
  assign cnt_miss     = cnt_miss_q;

endmodule

// File: tb/tb_dcache_line_nway.sv
// Randomised self-checking bench for dcache_line_nway (2 ways, 4-word lines)
// against a transaction-level cache/memory model.
module tb_dcache_line_nway;

  localparam int WAYS  = 2;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dcache_addr, dcache_in, dcache_out;
  logic [3:0]  byteenable;
  logic        dcache_rdreq, dcache_wrreq, dcache_valid, dcache_busy, invalidate;
  logic [31:0] mem_addr, mem_out, mem_in;
  logic        mem_wrreq, mem_wr_ack, mem_rdreq, mem_in_valid;
  logic [7:0]  cnt_miss;

  always #5 clk = ~clk;

  dcache_line_nway #(
    .DATABITS     (32),
    .ADDRBITS     (32),
    .CACHEADDRBITS(2),
    .LSBITS       (2),
    .WAYS         (WAYS),
    .WAYBITS      (1),
    .CNTMISSBITS  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dcache_addr (dcache_addr),
    .dcache_in   (dcache_in),
    .byteenable  (byteenable),
    .dcache_rdreq(dcache_rdreq),
    .dcache_wrreq(dcache_wrreq),
    .dcache_out  (dcache_out),
    .dcache_valid(dcache_valid),
    .dcache_busy (dcache_busy),
    .invalidate  (invalidate),
    .mem_addr    (mem_addr),
    .mem_out     (mem_out),
    .mem_wrreq   (mem_wrreq),
    .mem_wr_ack  (mem_wr_ack),
    .mem_rdreq   (mem_rdreq),
    .mem_in      (mem_in),
    .mem_in_valid(mem_in_valid),
    .cnt_miss    (cnt_miss)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // bmem: memory device as seen by the DUT. mm: the model's idea of memory.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] mm   [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h80:  return 32'h0000_00A0;
      32'h84:  return 32'h0000_00A1;
      32'h88:  return 32'h0000_0000;
      32'h8C:  return 32'h0000_00A3;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : init_word(a);
  endfunction

  // Reference model: per-way line contents plus round-robin pointer.
  bit          m_valid [WAYS];
  bit          m_dirty [WAYS];
  logic [27:0] m_tag   [WAYS];
  logic [31:0] m_data  [WAYS][WORDS];
  int          m_ptr;
  int          m_miss;
  logic [31:0] exp_wb_addr[$];
  logic [31:0] exp_wb_data[$];
  logic [31:0] exp_fill[$];
  bit          rand_stall;

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
    end
    m_ptr  = 0;
    m_miss = 0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output logic [31:0] rd, output bit hit);
    logic [27:0] t;
    logic [31:0] la, mask;
    logic [1:0]  wi;
    int          way, wd;
    t   = a[31:4];
    wd  = int'(a[3:2]);
    way = -1;
    for (int w = 0; w < WAYS; w++) if (way < 0 && m_valid[w] && m_tag[w] == t) way = w;
    hit = (way >= 0);
    if (!hit) begin
      if (m_miss < 255) m_miss++;
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[w]) way = w;
      if (way < 0) way = m_ptr;
      if (m_valid[way] && m_dirty[way]) begin
        for (int i = 0; i < WORDS; i++) begin
          wi = 2'(i);
          la = {m_tag[way], wi, 2'b00};
          exp_wb_addr.push_back(la);
          exp_wb_data.push_back(m_data[way][i]);
          mm[la] = m_data[way][i];
        end
      end
      for (int i = 0; i < WORDS; i++) begin
        wi = 2'(i);
        la = {t, wi, 2'b00};
        exp_fill.push_back(la);
        m_data[way][i] = mm_rd(la);
      end
      m_tag[way]   = t;
      m_valid[way] = 1;
      m_dirty[way] = 0;
      if (way == m_ptr) m_ptr = (m_ptr + 1) % WAYS;
    end
    rd = m_data[way][wd];
    if (wr) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      m_data[way][wd] = (m_data[way][wd] & ~mask) | (d & mask);
      m_dirty[way] = 1;
    end
  endtask

  function automatic bit want_stall(input bit stall3, input int beat, inout int st_cnt);
    if (stall3 && beat == 1 && st_cnt < 3) begin
      st_cnt++;
      return 1;
    end
    return rand_stall && ($urandom_range(0, 3) == 0);
  endfunction

  // One CPU request, acting as the memory device until dcache_valid.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit stall3, input string tag,
                        output logic [31:0] rd_o);
    logic [31:0] exp_rd;
    bit          hit, done, saw_busy;
    int          cyc, stalls, wb_beats, fill_beats, wb_st, fill_st;
    model_access(wr, a, d, be, exp_rd, hit);
    wb_beats   = exp_wb_addr.size();
    fill_beats = exp_fill.size();
    @(negedge clk);
    dcache_addr  = a;
    dcache_in    = d;
    byteenable   = be;
    dcache_wrreq = wr;
    dcache_rdreq = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; stalls = 0; done = 0; saw_busy = 0; wb_st = 0; fill_st = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      dcache_rdreq = 0;
      dcache_wrreq = 0;
      mem_wr_ack   = 0;
      mem_in_valid = 0;
      if (dcache_valid) begin
        done = 1;
      end else begin
        if (dcache_busy) saw_busy = 1;
        if (mem_wrreq) begin
          if (exp_wb_addr.size() == 0) begin
            check_val({tag, "/wb_unexpected"}, 32'(mem_wrreq), 32'd0);
          end else begin
            check_val({tag, "/wb_addr"}, mem_addr, exp_wb_addr[0]);
            check_val({tag, "/wb_data"}, mem_out, exp_wb_data[0]);
            if (want_stall(stall3, wb_beats - exp_wb_addr.size(), wb_st)) begin
              stalls++;
              if (stall3) check_val({tag, "/wb_stall_busy"}, 32'(dcache_busy), 32'd1);
            end else begin
              mem_wr_ack      = 1;
              bmem[mem_addr]  = mem_out;
              void'(exp_wb_addr.pop_front());
              void'(exp_wb_data.pop_front());
            end
          end
        end
        if (mem_rdreq) begin
          if (exp_fill.size() == 0) begin
            check_val({tag, "/fill_unexpected"}, 32'(mem_rdreq), 32'd0);
          end else begin
            check_val({tag, "/fill_addr"}, mem_addr, exp_fill[0]);
            if (want_stall(stall3, fill_beats - exp_fill.size(), fill_st)) begin
              stalls++;
              if (stall3) check_val({tag, "/fill_stall_busy"}, 32'(dcache_busy), 32'd1);
            end else begin
              mem_in_valid = 1;
              mem_in       = bmem_rd(mem_addr);
              void'(exp_fill.pop_front());
            end
          end
        end
      end
    end
    mem_wr_ack   = 0;
    mem_in_valid = 0;
    rd_o = dcache_out;
    check_val({tag, "/completed"}, 32'(done), 32'd1);
    if (done) begin
      if (!wr) check_val({tag, "/rdata"}, dcache_out, exp_rd);
      check_val({tag, "/latency"}, 32'(cyc),
                hit ? 32'd1 : 32'(2 + wb_beats + fill_beats + stalls));
      check_val({tag, "/busy_seen"}, 32'(saw_busy), 32'(!hit));
      check_val({tag, "/busy_at_valid"}, 32'(dcache_busy), 32'd0);
      check_val({tag, "/wb_left"}, 32'(exp_wb_addr.size()), 32'd0);
      check_val({tag, "/fill_left"}, 32'(exp_fill.size()), 32'd0);
    end
    check_val({tag, "/cnt_miss"}, 32'(cnt_miss), 32'(m_miss));
    exp_wb_addr.delete();
    exp_wb_data.delete();
    exp_fill.delete();
  endtask

  task automatic do_inval(input logic [31:0] a);
    @(negedge clk);
    invalidate   = 1;
    dcache_addr  = a;
    dcache_rdreq = 1'($urandom_range(0, 1));
    @(negedge clk);
    invalidate   = 0;
    dcache_rdreq = 0;
    check_val("inval/no_valid", 32'(dcache_valid), 32'd0);
    check_val("inval/no_busy", 32'(dcache_busy), 32'd0);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[w] = 0;
      m_dirty[w] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "/dcache_out"}, dcache_out, 32'd0);
    check_val({tag, "/dcache_valid"}, 32'(dcache_valid), 32'd0);
    check_val({tag, "/dcache_busy"}, 32'(dcache_busy), 32'd0);
    check_val({tag, "/mem_addr"}, mem_addr, 32'd0);
    check_val({tag, "/mem_out"}, mem_out, 32'd0);
    check_val({tag, "/mem_wrreq"}, 32'(mem_wrreq), 32'd0);
    check_val({tag, "/mem_rdreq"}, 32'(mem_rdreq), 32'd0);
    check_val({tag, "/cnt_miss"}, 32'(cnt_miss), 32'd0);
  endtask

  // Start a read miss and pull reset while fill word 1 is being requested.
  task automatic do_reset_midfill(input logic [31:0] a);
    logic [31:0] dummy;
    bit          hit, fired;
    int          cyc;
    model_access(1'b0, a, 32'd0, 4'd0, dummy, hit);
    @(negedge clk);
    dcache_addr  = a;
    dcache_rdreq = 1;
    fired = 0;
    cyc   = 0;
    while (!fired && cyc < 100) begin
      @(negedge clk);
      cyc++;
      dcache_rdreq = 0;
      mem_wr_ack   = 0;
      mem_in_valid = 0;
      if (mem_wrreq) begin
        mem_wr_ack     = 1;
        bmem[mem_addr] = mem_out;
      end else if (mem_rdreq) begin
        if (mem_addr[3:2] == 2'd1) begin
          #2 reset = 1;
          #1 check_all_zero("rst_midfill");
          fired = 1;
        end else begin
          mem_in_valid = 1;
          mem_in       = bmem_rd(mem_addr);
        end
      end
    end
    mem_wr_ack   = 0;
    mem_in_valid = 0;
    check_val("rst_midfill/reached", 32'(fired), 32'd1);
    @(negedge clk);
    reset = 0;
    exp_wb_addr.delete();
    exp_wb_data.delete();
    exp_fill.delete();
    model_reset();
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic [3:0]  be;
    int          op;
    reset = 1;
    dcache_addr = 0; dcache_in = 0; byteenable = 0;
    dcache_rdreq = 0; dcache_wrreq = 0; invalidate = 0;
    mem_wr_ack = 0; mem_in = 0; mem_in_valid = 0;
    rand_stall = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 0;

    do_req(0, 32'h80, 0, 0, 0, "cold_rd_80", rd);
    check_val("cold_rd_80/value", rd, 32'h0000_00A0);
    check_val("cold_rd_80/misses", 32'(cnt_miss), 32'd1);
    do_req(0, 32'h84, 0, 0, 0, "hit_rd_84", rd);
    check_val("hit_rd_84/value", rd, 32'h0000_00A1);
    do_req(1, 32'h88, 32'h1122_3344, 4'b0011, 0, "wr_88", rd);
    do_req(0, 32'h88, 0, 0, 0, "rd_88", rd);
    check_val("rd_88/value", rd, 32'h0000_3344);
    do_req(0, 32'h180, 0, 0, 0, "miss_180", rd);
    do_req(0, 32'h280, 0, 0, 1, "evict_280", rd);
    check_val("evict_280/misses", 32'(cnt_miss), 32'd3);
    check_val("evict_280/mem_88", bmem_rd(32'h88), 32'h0000_3344);
    do_req(1, 32'h184, 32'hDEAD_BEEF, 4'b1111, 0, "dirty_184", rd);
    do_inval(32'h184);
    do_req(0, 32'h84, 0, 0, 0, "post_inval_84", rd);
    check_val("post_inval_84/misses", 32'(cnt_miss), 32'd4);

    do_reset_midfill(32'h380);
    do_req(0, 32'h380, 0, 0, 0, "refetch_380", rd);
    check_val("refetch_380/misses", 32'(cnt_miss), 32'd1);

    rand_stall = 1;
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 11);
      a  = 32'h80 + 32'($urandom_range(0, 5)) * 32'h100 + 32'($urandom_range(0, 3)) * 4;
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      if (op == 0) do_inval(a);
      else if (op < 6) do_req(1, a, d, be, 0, "rand_wr", rd);
      else do_req(0, a, 0, 0, 0, "rand_rd", rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
